vt_strand_tx: RTL and testbench
===============================

VT_STRAND_TX -- requirements
Module: vt_strand_tx

Interface
REQ-001 Parameter N, default 10: codeword length in bits; N SHALL be 3 to 63.
REQ-002 Parameter A, default 5: VT syndrome target; 0 <= A <= N, otherwise elaboration SHALL fail.
REQ-003 Derived localparams SHALL be P = floor(log2 N)+1 parity bits and K = N-P message bits (N=10: P=4, K=6).
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 msg_in  input  K  message word, sampled on the input handshake.
REQ-007 in_valid  input  1  msg_in valid.
REQ-008 in_ready  output  1  block can accept a message.
REQ-009 bit_out  output  1  current serial codeword bit.
REQ-010 out_valid  output  1  bit_out valid.
REQ-011 out_ready  input  1  downstream (channel) accepts bit_out.
REQ-012 out_last  output  1  bit_out is position N.
REQ-013 codeword  output  N  full parallel codeword; bit [i-1] is position i.
REQ-014 cw_valid  output  1  codeword is stable and valid.
REQ-015 strand_cnt  output  16  number of strands fully transmitted.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, PARITY and SEND.
REQ-018 IDLE: in_ready=1; on in_valid&&in_ready, latch msg_in, clear the accumulator, set position index i=1, and go to ACCUM.
REQ-019 Placement: message bit m[j] SHALL go to the j-th non-power-of-two position in ascending order; power-of-two positions hold 0 during ACCUM (N=10: m[0..5] -> positions 3,5,6,7,9,10).
REQ-020 ACCUM: one position per cycle for i=1..N; if the bit at i is 1, acc <= (acc+i) mod (N+1), implemented as a single conditional subtract; after i=N, go to PARITY (N cycles total).
REQ-021 Accumulator and deficiency width SHALL be ceil(log2(N+1)) bits.
REQ-022 PARITY (1 cycle): d = A-acc if A >= acc, else A-acc+N+1; for each j, set position 2^j to bit j of d.
REQ-023 PARITY: register the codeword, set cw_valid, load the TX pointer to position 1, and go to SEND.
REQ-024 SEND: out_valid=1 and bit_out = codeword position pointer.
REQ-025 SEND: the pointer advances only on out_valid&&out_ready; with out_ready low, bit_out and the pointer hold indefinitely.
REQ-026 out_last SHALL be 1 exactly while the pointer is N.
REQ-027 On the handshake with out_last=1: strand_cnt increments, wrapping from 16'hFFFF to 0; cw_valid clears; the FSM returns to IDLE.
REQ-028 in_ready SHALL be 0 in ACCUM, PARITY and SEND; in_valid there is ignored and no message is lost or queued.
REQ-029 Latency: first out_valid SHALL occur N+2 cycles after the input handshake cycle; minimum strand period N+2+N cycles.
REQ-030 codeword SHALL remain unchanged from PARITY until the next PARITY; it is only valid while cw_valid=1.
REQ-031 Every emitted codeword SHALL satisfy sum(i*x_i) mod (N+1) = A.

Reset
REQ-032 On rst, asynchronously: FSM=IDLE, in_ready=1, out_valid=0, out_last=0, bit_out=0, cw_valid=0, busy=0, codeword=0, strand_cnt=0, accumulator=0, pointer=1.
REQ-033 Reset during ACCUM, PARITY or SEND SHALL discard the partial strand; a strand is never counted unless its last bit handshakes.
REQ-034 After rst deasserts, the first handshake SHALL be accepted on the next clock edge.

Verification
REQ-035 N=10, A=5, msg_in=6'b000000 with out_ready=1 -> codeword=10'b0000001001; serial 1,0,0,1,0,0,0,0,0,0; out_last on the 10th bit; strand_cnt=1.
REQ-036 msg_in=6'b111111 (acc=7, d=9) -> codeword=10'b1111110101; weighted sum 49 mod 11 = 5.
REQ-037 out_ready toggled pseudo-randomly during SEND -> bits are never dropped or duplicated; bit_out is stable while out_valid&&!out_ready; in_valid held high is never acknowledged before return to IDLE.
REQ-038 Reset asserted mid-SEND at bit 6 -> all outputs at reset values immediately (before the next edge); strand_cnt=0; the next message is encoded from scratch.
REQ-039 strand_cnt preloaded by sending 65535 strands (or forced) -> one more strand gives strand_cnt=0.
REQ-040 Exhaustive sweep of all 64 messages -> each codeword's syndrome equals 5 and its data positions equal msg_in; latency is 12 cycles.

Source files
------------

// File: rtl/vt_strand_tx.sv
// vt_strand_tx -- Varshamov-Tenengolts strand encoder with serial output.
//
// Takes a K-bit message, spreads it over the non-power-of-two positions of
// an N-bit codeword, accumulates the weighted position sum modulo N+1 one
// position per cycle, then fills the power-of-two positions with the binary
// deficiency so that sum(i*x_i) mod (N+1) == A.  The finished codeword is
// presented in parallel and shifted out serially, position 1 first, under a
// valid/ready handshake.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   msg_in[K-1:0]   message word, taken on in_valid && in_ready
//   in_valid        message valid
//   in_ready        block is idle and can take a message
//   bit_out         current serial codeword bit
//   out_valid       bit_out valid
//   out_ready       downstream accepts bit_out
//   out_last        bit_out is position N
//   codeword[N-1:0] parallel codeword, bit [i-1] is position i
//   cw_valid        codeword is valid
//   strand_cnt      number of strands whose last bit was accepted (wraps)
//   busy            high whenever the FSM is not idle
module vt_strand_tx #(
  parameter int N = 10,
  parameter int A = 5,
  // P = floor(log2 N) + 1, which is also the accumulator width ceil(log2(N+1))
  localparam int P = $clog2(N + 1),
  localparam int K = N - P
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [K-1:0]  msg_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          bit_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [N-1:0]  codeword,
  output logic          cw_valid,
  output logic [15:0]   strand_cnt,
  output logic          busy
);

  if (N < 3 || N > 63 || A < 0 || A > N) begin : g_param_check
    $error("vt_strand_tx: N must be 3..63 and A must be 0..N");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, PARITY, SEND} state_t;

  localparam logic [P-1:0] ONE_P = P'(1);
  localparam logic [P-1:0] N_P   = P'(N);
  localparam logic [P-1:0] A_P   = P'(A);
  // Modulus N+1; wraps to zero when N+1 == 2**P, which is still correct
  // because P-bit arithmetic is then already modulo N+1.
  localparam logic [P-1:0] MOD_P = P'(N + 1);
  localparam logic [P:0]   MOD_W = (P + 1)'(N + 1);

  // Place message bits on the non-power-of-two positions, ascending.
  function automatic logic [N-1:0] place_bits(input logic [K-1:0] m);
    logic [N-1:0] r;
    int j;
    r = '0;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        r[p-1] = m[j];
        j++;
      end
    end
    return r;
  endfunction

  // Put bit j of the deficiency on position 2**j.
  function automatic logic [N-1:0] parity_bits(input logic [P-1:0] d);
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < P; j++) begin
      r[(1 << j) - 1] = d[j];
    end
    return r;
  endfunction

  state_t        state;
  logic [K-1:0]  msg;
  logic [P-1:0]  acc;
  logic [P-1:0]  idx;
  logic [P-1:0]  ptr;

  logic [N-1:0]  placed;
  logic          cur_bit;
  logic [P:0]    sum;
  logic [P:0]    acc_step;
  logic [P-1:0]  defic;
  logic [N-1:0]  cw_next;

  // Datapath: data placement, modular accumulate step and deficiency.
  always_comb begin
    placed  = place_bits(msg);
    cur_bit = placed[idx - ONE_P];
    sum     = {1'b0, acc} + {1'b0, idx};
    // acc < N+1 and idx <= N, so one conditional subtract gives the modulus
    if (sum >= MOD_W) begin
      acc_step = sum - MOD_W;
    end else begin
      acc_step = sum;
    end
    if (A_P >= acc) begin
      defic = A_P - acc;
    end else begin
      defic = A_P - acc + MOD_P;
    end
    cw_next = placed | parity_bits(defic);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      msg        <= '0;
      acc        <= '0;
      idx        <= ONE_P;
      ptr        <= ONE_P;
      codeword   <= '0;
      cw_valid   <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      bit_out    <= 1'b0;
      busy       <= 1'b0;
      strand_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            msg      <= msg_in;
            acc      <= '0;
            idx      <= ONE_P;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (cur_bit) begin
            acc <= acc_step[P-1:0];
          end
          if (idx == N_P) begin
            state <= PARITY;
          end else begin
            idx <= idx + ONE_P;
          end
        end
        PARITY: begin
          codeword  <= cw_next;
          cw_valid  <= 1'b1;
          ptr       <= ONE_P;
          bit_out   <= cw_next[0];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (ptr == N_P) begin
              strand_cnt <= strand_cnt + 16'd1;
              cw_valid   <= 1'b0;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              bit_out    <= 1'b0;
              ptr        <= ONE_P;
              in_ready   <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              ptr      <= ptr + ONE_P;
              // codeword[ptr] is position ptr+1
              bit_out  <= codeword[ptr];
              out_last <= ((ptr + ONE_P) == N_P);
            end
          end
        end
        default: begin
          state     <= IDLE;
          cw_valid  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          bit_out   <= 1'b0;
          ptr       <= ONE_P;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vt_strand_tx.sv
// Testbench for vt_strand_tx (N=10, A=5): directed vectors with
// hand-computed codewords feed a scoreboard queue; a monitor collects the
// serial stream and checks it against the queue, the parallel codeword,
// the VT syndrome and the data positions.
module tb_vt_strand_tx;
  localparam int N = 10;
  localparam int A = 5;
  localparam int K = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [K-1:0]  msg_in;
  logic          in_valid;
  logic          in_ready;
  logic          bit_out;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [N-1:0]  codeword;
  logic          cw_valid;
  logic [15:0]   strand_cnt;
  logic          busy;

  vt_strand_tx #(.N(N), .A(A)) dut (
    .clk(clk), .rst(rst), .msg_in(msg_in), .in_valid(in_valid),
    .in_ready(in_ready), .bit_out(bit_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .codeword(codeword),
    .cw_valid(cw_valid), .strand_cnt(strand_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] cw;
    bit           known;
    logic [K-1:0] msg;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rnd_ready = 1'b0;
  int   exp_cnt = 0;

  // Data positions of m[0..5], worked out by hand for N=10
  int dpos [K] = '{3, 5, 6, 7, 9, 10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // out_ready driver: always ready, or pseudo-random stalls
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: assembles serial strands and checks them against the scoreboard
  initial begin
    int           pos;
    int           s;
    logic [N-1:0] ser;
    logic [K-1:0] dat;
    bit           stall;
    logic         sbit;
    exp_t         e;
    pos = 0;
    stall = 1'b0;
    sbit = 1'b0;
    ser = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pos = 0;
        stall = 1'b0;
        exp_q.delete();
      end else begin
        if (busy) check("in_ready_while_busy", in_ready, 0);
        if (stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_bit", bit_out, sbit);
        end
        stall = out_valid && !out_ready;
        sbit  = bit_out;
        if (out_valid && out_ready) begin
          check("out_last_pos", out_last, (pos == N - 1) ? 1 : 0);
          ser[pos] = bit_out;
          pos++;
          if (pos == N) begin
            pos = 0;
            if (exp_q.size() == 0) begin
              check("unexpected_strand", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              if (e.known) check("serial_cw", ser, e.cw);
              check("parallel_cw", codeword, ser);
              check("cw_valid_send", cw_valid, 1);
              s = 0;
              for (int i = 1; i <= N; i++) if (ser[i-1]) s += i;
              check("syndrome", s % (N + 1), A);
              for (int j = 0; j < K; j++) dat[j] = ser[dpos[j]-1];
              check("data_pos", dat, e.msg);
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("strand_done", busy, 0);
    check("cw_valid_clr", cw_valid, 0);
    check("out_valid_clr", out_valid, 0);
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    check("strand_cnt", strand_cnt, exp_cnt);
  endtask

  task automatic send(input logic [K-1:0] m, input bit known, input logic [N-1:0] cw);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_in_ready", in_ready, 1);
    in_valid = 1'b1;
    msg_in = m;
    exp_q.push_back('{cw, known, m});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // count cycles from the handshake cycle to the first out_valid
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rnd_ready) check("latency", n, N + 2);
    wait_idle();
  endtask

  logic [K-1:0] vec_msg [6] = '{6'b000000, 6'b111111, 6'b000001, 6'b100000, 6'b010100, 6'b001010};
  logic [N-1:0] vec_cw  [6] = '{10'b0000001001, 10'b1111110101, 10'b0000000110,
                                10'b1000001010, 10'b0100100001, 10'b0001011000};

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    msg_in = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_cw_valid", cw_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_codeword", codeword, 0);
    check("rst_strand_cnt", strand_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed vectors, channel always ready
    for (int v = 0; v < 6; v++) send(vec_msg[v], 1'b1, vec_cw[v]);

    // random back-pressure
    rnd_ready = 1'b1;
    send(vec_msg[1], 1'b1, vec_cw[1]);
    send(vec_msg[4], 1'b1, vec_cw[4]);

    // in_valid held high through a whole strand: exactly two strands result
    in_valid = 1'b1;
    msg_in = vec_msg[5];
    exp_q.push_back('{vec_cw[5], 1'b1, vec_msg[5]});
    @(posedge clk);
    #1;
    wait_idle();
    exp_q.push_back('{vec_cw[5], 1'b1, vec_msg[5]});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    rnd_ready = 1'b0;

    // reset while bit 6 is on the line
    in_valid = 1'b1;
    msg_in = vec_msg[1];
    exp_q.push_back('{vec_cw[1], 1'b1, vec_msg[1]});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("mid_send_valid", out_valid, 1);
    check("mid_send_bit6", bit_out, vec_cw[1][5]);
    rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_last", out_last, 0);
    check("arst_bit_out", bit_out, 0);
    check("arst_cw_valid", cw_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_codeword", codeword, 0);
    check("arst_strand_cnt", strand_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    send(vec_msg[3], 1'b1, vec_cw[3]);

    // sweep of every message: syndrome, data positions and latency
    for (int m = 0; m < 64; m++) send(6'(m), 1'b0, '0);

    // counter wrap
    force dut.strand_cnt = 16'hFFFF;
    #1;
    release dut.strand_cnt;
    exp_cnt = 16'hFFFF;
    send(vec_msg[0], 1'b1, vec_cw[0]);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
